// File: rtl/div_bus_ctrl.sv
// Byte-wide register-bus front end for the 16-bit signed divider: it collects the
// operands, starts the divider, waits for its ready handshake and latches the result.
//
// state     | meaning
// IDLE      | waiting for GO; bus writes accepted
// START     | one-cycle div_start pulse, timeout budget loaded
// WAIT_ACK  | waiting for div_ready to drop (divider accepted)
// WAIT_DONE | waiting for div_ready to rise, then latch Q/R
module div_bus_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   addr,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [7:0]   wdata,
  output logic [7:0]   rdata,
  output logic         irq,
  output logic         div_start,
  output logic [W-1:0] div_A,
  output logic [W-1:0] div_B,
  input  logic         div_ready,
  input  logic [W-1:0] div_Q,
  input  logic [W-1:0] div_R
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg, b_reg, q_reg, r_reg;
  logic          done, dz, to, dz_pend;
  logic          busy, wr_ok, go, clr, status_rd;
  logic          latch_res, timeout_hit;
  logic [7:0]    rd_mux;

  assign busy      = (state != IDLE);
  assign wr_ok     = wr_en && !busy;
  assign go        = wr_ok && (addr == 4'd4) && wdata[0];
  assign clr       = wr_ok && (addr == 4'd4) && wdata[1] && !wdata[0];
  assign status_rd = rd_en && (addr == 4'd5);

  assign div_start = (state == START);
  assign div_A     = a_reg;
  assign div_B     = b_reg;
  assign irq       = done;

  always_comb begin
    state_nxt   = state;
    latch_res   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (go && (b_reg != '0)) state_nxt = START;
      START:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (!div_ready) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == '0) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (div_ready) begin
          latch_res = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // One budget covers both wait states together.
      if (state == START)
        cnt <= CW'(TIMEOUT - 1);
      else if (busy && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (wr_ok) begin
      case (addr)
        4'd0: a_reg[7:0]  <= wdata;
        4'd1: a_reg[15:8] <= wdata;
        4'd2: b_reg[7:0]  <= wdata;
        4'd3: b_reg[15:8] <= wdata;
        default: ;
      endcase
    end
  end

  // Set events take priority over clears so a completion is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= 1'b0;
      dz      <= 1'b0;
      to      <= 1'b0;
      dz_pend <= 1'b0;
      q_reg   <= '0;
      r_reg   <= '0;
    end else begin
      dz_pend <= go && (b_reg == '0);

      if (dz_pend || latch_res || timeout_hit) done <= 1'b1;
      else if (go || clr || status_rd)        done <= 1'b0;

      if (dz_pend)          dz <= 1'b1;
      else if (go || clr)   dz <= 1'b0;

      if (timeout_hit)      to <= 1'b1;
      else if (go || clr)   to <= 1'b0;

      if (latch_res) begin
        q_reg <= div_Q;
        r_reg <= div_R;
      end else if (dz_pend) begin
        q_reg <= '1;
        r_reg <= a_reg;
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      4'd0: rd_mux = a_reg[7:0];
      4'd1: rd_mux = a_reg[15:8];
      4'd2: rd_mux = b_reg[7:0];
      4'd3: rd_mux = b_reg[15:8];
      4'd5: rd_mux = {4'b0000, to, dz, done, busy};
      4'd6: rd_mux = q_reg[7:0];
      4'd7: rd_mux = q_reg[15:8];
      4'd8: rd_mux = r_reg[7:0];
      4'd9: rd_mux = r_reg[15:8];
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rdata <= 8'h00;
    else if (rd_en) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_div_bus_ctrl.sv
// Directed bench for div_bus_ctrl with a behavioural signed divider attached;
// expected results are hand-computed constants.
module tb_div_bus_ctrl;

  localparam int TIMEOUT = 64;
  localparam int DIV_LAT = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        irq;
  logic        div_start;
  logic [15:0] div_A, div_B;
  logic        div_ready;
  logic [15:0] div_Q, div_R;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int s0;
  logic stuck = 1'b0;
  logic [7:0] rd;

  div_bus_ctrl #(.TIMEOUT(TIMEOUT), .W(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .irq(irq), .div_start(div_start),
    .div_A(div_A), .div_B(div_B), .div_ready(div_ready),
    .div_Q(div_Q), .div_R(div_R)
  );

  always #5 clk = ~clk;

  // Behavioural divider: ready drops after start, result appears DIV_LAT cycles later.
  int lat_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_ready <= 1'b1;
      div_Q     <= '0;
      div_R     <= '0;
      lat_cnt   <= 0;
    end else if (div_start && div_ready && !stuck) begin
      div_ready <= 1'b0;
      lat_cnt   <= DIV_LAT;
      div_Q     <= 16'($signed(div_A) / $signed(div_B));
      div_R     <= 16'($signed(div_A) % $signed(div_B));
    end else if (!div_ready) begin
      if (lat_cnt == 0) div_ready <= 1'b1;
      else              lat_cnt   <= lat_cnt - 1;
    end
  end

  always @(posedge clk) if (div_start) starts <= starts + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus_read(a, v);
    check(tag, {24'h0, v}, {24'h0, exp});
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    bus_write(4'd0, a[7:0]);
    bus_write(4'd1, a[15:8]);
    bus_write(4'd2, b[7:0]);
    bus_write(4'd3, b[15:8]);
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (irq) break;
      @(negedge clk);
    end
    check(tag, {31'h0, irq}, 32'h1);
  endtask

  task automatic check_qr(input string tag, input logic [15:0] q, input logic [15:0] r);
    read_check({tag, "_qlo"}, 4'd6, q[7:0]);
    read_check({tag, "_qhi"}, 4'd7, q[15:8]);
    read_check({tag, "_rlo"}, 4'd8, r[7:0]);
    read_check({tag, "_rhi"}, 4'd9, r[15:8]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdata", {24'h0, rdata}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_start", {31'h0, div_start}, 32'h0);
    rst = 1'b1;

    // Reset in the middle of a divide
    load_ops(16'd25, 16'd5);
    read_check("mid_alo", 4'd0, 8'h19);
    bus_write(4'd4, 8'h01);
    repeat (5) @(negedge clk);
    check("mid_busy_a", {16'h0, div_A}, 32'h19);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_outs", {rdata, 7'h0, irq, 7'h0, div_start}, 32'h0);
    check("mid_rst_ab", {div_A, div_B}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    read_check("mid_status", 4'd5, 8'h00);
    check_qr("mid", 16'h0000, 16'h0000);

    // Basic 25 / 5
    load_ops(16'h0019, 16'h0005);
    s0 = starts;
    bus_write(4'd4, 8'h01);
    wait_irq("basic_irq");
    check("basic_starts", starts - s0, 32'd1);
    read_check("basic_status", 4'd5, 8'h02);
    check("basic_irq_clr", {31'h0, irq}, 32'h0);
    read_check("basic_status2", 4'd5, 8'h00);
    check_qr("basic", 16'h0005, 16'h0000);

    // Signed 100 / -25
    load_ops(16'd100, 16'hFFE7);
    bus_write(4'd4, 8'h01);
    wait_irq("signed_irq");
    read_check("signed_status", 4'd5, 8'h02);
    check_qr("signed", 16'hFFFC, 16'h0000);

    // Timeout: divider never acknowledges
    stuck = 1'b1;
    load_ops(16'd7, 16'd2);
    bus_write(4'd4, 8'h01);
    repeat (TIMEOUT - 4) @(negedge clk);
    check("to_early", {31'h0, irq}, 32'h0);
    wait_irq("to_irq");
    read_check("to_status", 4'd5, 8'h0A);
    check_qr("to", 16'hFFFC, 16'h0000);
    stuck = 1'b0;
    bus_write(4'd4, 8'h01);
    wait_irq("after_to_irq");
    read_check("after_to_status", 4'd5, 8'h02);
    check_qr("after_to", 16'h0003, 16'h0001);

    // Divide by zero, then CLR
    load_ops(16'd23, 16'd0);
    s0 = starts;
    bus_write(4'd4, 8'h01);
    @(negedge clk);
    check("dz_irq", {31'h0, irq}, 32'h1);
    read_check("dz_status", 4'd5, 8'h06);
    check("dz_starts", starts - s0, 32'd0);
    check_qr("dz", 16'hFFFF, 16'h0017);
    read_check("dz_status2", 4'd5, 8'h04);
    bus_write(4'd4, 8'h02);
    read_check("clr_status", 4'd5, 8'h00);
    check_qr("clr_keep", 16'hFFFF, 16'h0017);

    // Writes and GO ignored while busy
    load_ops(16'd0, 16'd8);
    s0 = starts;
    bus_write(4'd4, 8'h01);
    bus_write(4'd0, 8'h55);
    bus_write(4'd4, 8'h01);
    read_check("busy_status", 4'd5, 8'h01);
    wait_irq("busy_irq");
    repeat (30) @(negedge clk);
    check("busy_starts", starts - s0, 32'd1);
    read_check("busy_alo", 4'd0, 8'h00);
    check_qr("busy", 16'h0000, 16'h0000);

    // GO and CLR together: GO wins
    load_ops(16'hFFF9, 16'd2);
    s0 = starts;
    bus_write(4'd4, 8'h03);
    wait_irq("goclr_irq");
    check("goclr_starts", starts - s0, 32'd1);
    read_check("goclr_status", 4'd5, 8'h02);
    check_qr("goclr", 16'hFFFD, 16'hFFFF);
    read_check("unmapped", 4'd12, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_bus_ctrl.md
Name: div_bus_ctrl

Overview:
- Byte-wide register-bus front end and sequencer for the 16-bit signed restoring divider (`divider`).
- A bus master writes A and B a byte at a time, then writes GO. The block pulses the divider's start, tracks its ready handshake and latches Q/R. It reports completion, divide-by-zero and timeout through STATUS and an irq line.
- Sits between the 8-bit system bus and one `divider` instance.

Parameters:
- TIMEOUT, 64, max clk cycles spent in WAIT_ACK + WAIT_DONE before aborting (>= divider worst-case latency + 4).
- W, 16, operand/result width. Fixed at 16 for this block; bus mapping assumes 2 bytes.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- addr  in  4  register address.
- wr_en  in  1  bus write strobe, one-cycle, samples wdata/addr.
- rd_en  in  1  bus read strobe, one-cycle.
- wdata  in  8  write data.
- rdata  out  8  read data, registered, valid cycle after rd_en.
- irq  out  1  level interrupt; high while DONE flag set.
- div_start  out  1  one-cycle start pulse to divider.
- div_A  out  16  dividend, held stable from start until done.
- div_B  out  16  divisor, held stable from start until done.
- div_ready  in  1  divider ready/idle indication.
- div_Q  in  16  divider quotient.
- div_R  in  16  divider remainder.

Behaviour:
- Register map:
  - 0 A_LO, 1 A_HI, 2 B_LO, 3 B_HI: read/write.
  - 4 CTRL: write bit0=GO, bit1=CLR; reads 0.
  - 5 STATUS: read-only; bit0 BUSY, bit1 DONE, bit2 DZ, bit3 TO.
  - 6 Q_LO, 7 Q_HI, 8 R_LO, 9 R_HI: read-only.
  - 10-15: read 0x00, writes ignored.
- Reset (rst=0, async):
  - All registers 0; state IDLE.
  - rdata=0, irq=0, div_start=0, div_A=div_B=0.
  - Any operation in flight is abandoned.
- FSM states:
  - IDLE: wait for GO.
  - START: div_start=1 for exactly one cycle, timeout counter cleared. Then WAIT_ACK.
  - WAIT_ACK: wait div_ready=0 (divider accepted). Then WAIT_DONE.
  - WAIT_DONE: on div_ready=1, latch div_Q/div_R, set DONE. Then IDLE.
  - Timeout: if the counter reaches TIMEOUT in WAIT_ACK or WAIT_DONE, set TO and DONE, keep old Q/R, go to IDLE.
- GO in IDLE:
  - B==0: do not start the divider. Set DZ and DONE, Q=0xFFFF, R=A, next cycle, stay IDLE.
  - Otherwise go to START.
  - Either way, DZ/TO/DONE are cleared in the GO cycle before the new result.
- BUSY = state != IDLE.
- While BUSY:
  - Writes to addr 0-3 and GO are ignored.
  - CLR is ignored.
  - Reads of Q/R return the previous result.
- CLR in IDLE clears DONE, DZ and TO; Q/R are retained.
- Reading STATUS clears DONE (read-to-clear). The returned byte shows the pre-clear value.
- irq = DONE.
- GO and CLR set in the same write: GO wins.
- Reading STATUS in the same cycle DONE is set: the new set wins; DONE stays 1 and the returned value may show 0.
- div_A/div_B are driven from the operand registers; they are frozen because writes are blocked while BUSY.
- Signed semantics belong entirely to the divider; the controller passes bits unchanged.
- Latency: GO write to div_start = 1 cycle. div_ready=1 in WAIT_DONE to DONE/irq = 1 cycle.

Test Plan:
- Reset mid-run: GO with A=25, B=5; assert rst=0 during WAIT_DONE -> all outputs 0 immediately. After release, STATUS=0x00 and Q=R=0.
- Basic: write A=0x0019, B=0x0005, GO -> one div_start pulse, irq rises. STATUS=0x02, Q=0x0005, R=0x0000. The STATUS read drops irq, and a second STATUS read returns 0x00.
- Signed: A=100, B=0xFFE7 (-25) -> Q=0xFFFC, R=0x0000, DZ=0, TO=0.
- Divide by zero: A=23, B=0, GO -> div_start never pulses. Next cycle STATUS=0x06, Q=0xFFFF, R=0x0017.
- Busy protection: GO with A=0, B=8; while BUSY write A_LO=0x55 and a second GO -> ignored, single div_start. Q=0, R=0, A_LO reads 0x00.
- Timeout: divider model holds div_ready=1 forever after start -> after TIMEOUT cycles STATUS=0x0A, Q/R unchanged, FSM back to IDLE, next GO accepted.
